// File: rtl/variance_to_sqrt_feeder.sv
// variance_to_sqrt_feeder
// Accumulates windows of 2^LOG2_N signed samples and hands the exact floor
// population variance of each window to the integer square-root unit as its
// radicand. Input is blocked while the radicand is being computed and the
// sqrt unit is working.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous abort: flush the window, abandon any sqrt in flight
//   s_valid     sample valid
//   s_data      signed sample
//   s_ready     sample accepted when s_valid & s_ready (high only in ACCUM)
//   sq_start    one-cycle start pulse to the sqrt unit
//   sq_x        radicand (variance), held between windows, always >= 0
//   sq_done     sqrt completion pulse, honoured only in WAIT
//   busy        high in CALC, ISSUE and WAIT
//   win_cnt     completed windows, wraps at 2^16
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting samples into S (sum) and Q (sum of squares)
// CALC  | one cycle: register sq_x = (N*Q - S*S) >> (2*LOG2_N)
// ISSUE | one cycle: sq_start high, win_cnt increments
// WAIT  | waiting for sq_done, then clear the window and return to ACCUM
module variance_to_sqrt_feeder #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 4,
  parameter int OUT_W  = 2 * DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     s_ready,
  output logic                     sq_start,
  output logic signed [OUT_W-1:0]  sq_x,
  input  logic                     sq_done,
  output logic                     busy,
  output logic [15:0]              win_cnt
);

  localparam int SUM_W = DATA_W + LOG2_N;
  localparam int SQ_W  = 2 * DATA_W + LOG2_N;
  localparam int IW    = 2 * DATA_W + 2 * LOG2_N + 1;

  // Counter value just before the accept that completes the window.
  localparam logic [LOG2_N:0] N_LAST = {1'b0, {LOG2_N{1'b1}}};

  typedef enum logic [1:0] {
    ACCUM,
    CALC,
    ISSUE,
    WAIT
  } state_t;

  state_t                    state;
  logic signed [SUM_W-1:0]   s_sum;
  logic        [SQ_W-1:0]    q_sum;
  logic        [LOG2_N:0]    cnt;

  // Sample square: widen first so the product is exact at 2*DATA_W bits.
  logic signed [2*DATA_W-1:0] samp_ext;
  logic signed [2*DATA_W-1:0] samp_sq;
  logic signed [SUM_W-1:0]    samp_wide;

  assign samp_ext  = {{DATA_W{s_data[DATA_W-1]}}, s_data};
  assign samp_sq   = samp_ext * samp_ext;
  assign samp_wide = {{LOG2_N{s_data[DATA_W-1]}}, s_data};

  // N*Q - S*S in IW bits; the difference is never negative, so the shifted
  // result fits OUT_W with a zero MSB and only the middle slice is kept.
  logic        [IW-1:0] nq;
  logic signed [IW-1:0] s_ext;
  logic signed [IW-1:0] s_sq;
  logic        [IW-1:0] diff;
  logic        [OUT_W-1:0] var_next;
  logic                 unused_diff_bits;

  assign nq       = {{(LOG2_N + 1){1'b0}}, q_sum} << LOG2_N;
  assign s_ext    = {{(IW - SUM_W){s_sum[SUM_W-1]}}, s_sum};
  assign s_sq     = s_ext * s_ext;
  assign diff     = nq - s_sq;
  assign var_next = diff[2*LOG2_N +: OUT_W];
  assign unused_diff_bits = ^{diff[IW-1], diff[2*LOG2_N-1:0]};

  assign s_ready = (state == ACCUM);
  assign busy    = (state != ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      s_sum    <= '0;
      q_sum    <= '0;
      cnt      <= '0;
      sq_start <= 1'b0;
      sq_x     <= '0;
      win_cnt  <= '0;
    end else begin
      sq_start <= 1'b0;
      if (clear) begin
        // Abort wins over everything, including a same-cycle sample.
        state <= ACCUM;
        s_sum <= '0;
        q_sum <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (s_valid) begin
              s_sum <= s_sum + samp_wide;
              q_sum <= q_sum + {{LOG2_N{1'b0}}, samp_sq};
              cnt   <= cnt + (LOG2_N + 1)'(1);
              if (cnt == N_LAST) state <= CALC;
            end
          end
          CALC: begin
            sq_x     <= var_next;
            sq_start <= 1'b1;
            state    <= ISSUE;
          end
          ISSUE: begin
            win_cnt <= win_cnt + 16'd1;
            state   <= WAIT;
          end
          WAIT: begin
            if (sq_done) begin
              s_sum <= '0;
              q_sum <= '0;
              cnt   <= '0;
              state <= ACCUM;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_variance_to_sqrt_feeder.sv
// Bench for variance_to_sqrt_feeder (DATA_W=16, LOG2_N=2): table of windows
// with known variances, a reference model feeding a scoreboard of expected
// sq_start events, a stub sqrt unit, and hand sequences for backpressure,
// clear and asynchronous reset.
module tb_variance_to_sqrt_feeder;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 2;
  localparam int OUT_W  = 2 * DATA_W;

  logic                     clk;
  logic                     rst_n;
  logic                     clear;
  logic                     s_valid;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_ready;
  logic                     sq_start;
  logic signed [OUT_W-1:0]  sq_x;
  logic                     sq_done;
  logic                     busy;
  logic [15:0]              win_cnt;

  variance_to_sqrt_feeder #(
    .DATA_W(DATA_W),
    .LOG2_N(LOG2_N),
    .OUT_W (OUT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .sq_start(sq_start),
    .sq_x    (sq_x),
    .sq_done (sq_done),
    .busy    (busy),
    .win_cnt (win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model and scoreboard
  typedef struct {
    longint x;
    int     start_cyc;
    int     win;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     m_cnt = 0;
  longint m_sum = 0;
  longint m_sq  = 0;
  int     exp_win = 0;

  task automatic model_flush();
    m_cnt = 0;
    m_sum = 0;
    m_sq  = 0;
  endtask

  // Called when a sample is known to be accepted at the coming posedge.
  task automatic model_accept(input int v);
    exp_t e;
    m_sum += longint'(v);
    m_sq  += longint'(v) * longint'(v);
    m_cnt++;
    if (m_cnt == 4) begin
      e.x         = (4 * m_sq - m_sum * m_sum) / 16;
      e.start_cyc = cyc + 2;
      exp_win     = (exp_win + 1) % 65536;
      e.win       = exp_win;
      sb.push_back(e);
      model_flush();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sq_start) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_start actual sq_x=%0d required no start", sq_x);
      end else begin
        mon_e = sb.pop_front();
        chk("start_latency", cyc, mon_e.start_cyc);
        chk("sq_x", sq_x, mon_e.x);
        chk("sq_x_msb", sq_x[OUT_W-1], 0);
        @(negedge clk);
        chk("win_cnt", win_cnt, mon_e.win);
      end
    end
  end

  // Stub sqrt unit
  int     stub_delay = 5;
  int     stub_timer = 0;
  longint stub_x = 0;
  longint sqrt_result = -1;

  function automatic longint isqrt(input longint x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  initial begin
    sq_done = 1'b0;
    forever begin
      @(negedge clk);
      sq_done = 1'b0;
      if (!rst_n) begin
        stub_timer = 0;
      end else begin
        if (stub_timer > 0) begin
          stub_timer--;
          if (stub_timer == 0) begin
            sq_done     = 1'b1;
            sqrt_result = isqrt(stub_x);
          end
        end
        if (sq_start) begin
          stub_x     = longint'(sq_x);
          stub_timer = stub_delay;
        end
      end
    end
  end

  // Drivers
  task automatic drive_sample(input int v, output int waits);
    waits = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = v[15:0];
    while (!s_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual s_ready=0 required 1");
    end else begin
      model_accept(v);
    end
  endtask

  task automatic stop_valid();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual busy=1 required 0");
    end
  endtask

  task automatic send_window(input int d[4]);
    int w;
    for (int i = 0; i < 4; i++) drive_sample(d[i], w);
    stop_valid();
    wait_idle();
  endtask

  typedef struct {
    int     d[4];
    longint exp_x;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int w;
    int win4[4];
    int bp[8];

    tbl[0].d = '{1, 2, 3, 4};               tbl[0].exp_x = 1;
    tbl[1].d = '{5, 5, 5, 5};               tbl[1].exp_x = 0;
    tbl[2].d = '{-3, 3, -3, 3};             tbl[2].exp_x = 9;
    tbl[3].d = '{-32768, -32768, 32767, 32767}; tbl[3].exp_x = 1073709056;

    rst_n   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sq_start", sq_start, 0);
    chk("rst_sq_x", sq_x, 0);
    chk("rst_win_cnt", win_cnt, 0);

    // Table windows
    stub_delay = 5;
    for (int i = 0; i < 4; i++) begin
      send_window(tbl[i].d);
      chk("tbl_sq_x", sq_x, tbl[i].exp_x);
    end
    chk("sqrt_extreme", sqrt_result, 32767);
    chk("tbl_win_cnt", win_cnt, 4);

    // Random windows checked through the model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) win4[i] = int'($urandom_range(65535)) - 32768;
      send_window(win4);
    end

    // Backpressure with s_valid held high and a slow sqrt
    stub_delay = 20;
    bp = '{1, 2, 3, 4, 50, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      drive_sample(bp[i], w);
      if (i == 4) chk("bp_stall_cycles", w, 22);
      else if (i > 0 && i < 4) chk("bp_no_stall", w, 0);
    end
    stop_valid();
    wait_idle();
    chk("bp_win2_sq_x", sq_x, 468);

    // clear in WAIT, late done 3 cycles after clear
    stub_delay = 4;
    win4 = '{7, 7, 7, 15};
    for (int i = 0; i < 4; i++) drive_sample(win4[i], w);
    stop_valid();
    @(negedge clk);
    @(negedge clk);
    chk("pre_clear_busy", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_s_ready", s_ready, 1);
    chk("clear_busy", busy, 0);
    chk("clear_keeps_sq_x", sq_x, 12);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_done_ignored", s_ready, 1);
    end
    stub_delay = 5;
    win4 = '{1, 2, 3, 4};
    send_window(win4);
    chk("post_clear_sq_x", sq_x, 1);

    // clear in ACCUM drops the same-cycle sample and the partial window
    drive_sample(100, w);
    drive_sample(-100, w);
    @(negedge clk);
    s_data  = 16'sd555;
    clear   = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    s_valid = 1'b0;
    model_flush();
    send_window(win4);
    chk("post_flush_sq_x", sq_x, 1);

    // Asynchronous reset mid-window
    drive_sample(9, w);
    drive_sample(9, w);
    stop_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sq_x", sq_x, 0);
    chk("arst_win_cnt", win_cnt, 0);
    chk("arst_sq_start", sq_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_s_ready", s_ready, 1);
    model_flush();
    exp_win = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_window(win4);
    chk("post_rst_win_cnt", win_cnt, 1);
    chk("post_rst_sq_x", sq_x, 1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
